// File: rtl/max_pool_2x2_if.sv
// Streaming handshake between the ReLU stage, the 2x2 max-pool block and its
// consumer: sample input with valid/ready, pooled output with valid only.
interface max_pool_2x2_if #(
  parameter int DATA_W = 16
) ();

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;

  // Producer/consumer side (testbench or upstream logic)
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Pooling block side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-ordered IMG_W x IMG_H map.
// Horizontal pairs are reduced as they arrive; even-row pair maxima are parked
// in a half-width line buffer and combined with the matching odd-row pair.
module max_pool_2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             p_load,
  max_pool_2x2_if.slave    bus,
  output logic             done_p
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LN = IMG_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic signed [DATA_W-1:0] hold_q;
  logic signed [DATA_W-1:0] line_buf [LN];

  logic                     xfer;
  logic                     last_px;
  logic                     col_odd;
  logic                     row_odd;
  logic [LW-1:0]            lb_idx;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pool_max;

  // Transfer qualification and the signed max tree for the current sample
  always_comb begin
    xfer     = bus.in_valid && bus.in_ready;
    col_odd  = col_q[0];
    row_odd  = row_q[0];
    last_px  = xfer && (col_q == COL_LAST) && (row_q == ROW_LAST);
    lb_idx   = LW'(col_q >> 1);
    lb_rd    = line_buf[lb_idx];
    pair_max = (bus.in_data > hold_q) ? bus.in_data : hold_q;
    pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the state-decoded handshake/completion outputs
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    done_p       = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_load) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bus.in_ready = 1'b1;
        if (last_px) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_p  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Raster position: cleared by a start pulse in IDLE, advanced per transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if ((state_q == IDLE) && p_load) begin
      col_q <= '0;
      row_q <= '0;
    end else if (xfer) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Even-column sample waits here for its odd-column partner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (xfer && !col_odd) begin
      hold_q <= bus.in_data;
    end
  end

  // Even-row pair maxima; every entry is rewritten before its odd-row read
  always_ff @(posedge clk) begin
    if (xfer && col_odd && !row_odd) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

  // Pooled output: registered one cycle after each odd-row, odd-column transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= xfer && col_odd && row_odd;
      if (xfer && col_odd && row_odd) begin
        bus.out_data <= pool_max;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2 on a 4x4 map: table of frames with
// hand-computed pooled results, plus a mid-frame reset sequence.
module tb_max_pool_2x2;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NV = 7;

  typedef struct packed {
    logic [15:0][DW-1:0] pix;
    logic [3:0][DW-1:0]  exp;
    logic                bubble;
    logic                extra_pl;
    logic                idle_valid;
    logic                gap;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic p_load  = 1'b0;
  logic done_p;

  max_pool_2x2_if #(.DATA_W(DW)) bus ();

  max_pool_2x2 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .p_load  (p_load),
    .bus     (bus),
    .done_p  (done_p)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  int             done_seen = 0;
  int             m_state = 0;   // 0 idle, 1 run, 2 done
  int             m_idx = 0;
  logic           m_ov = 1'b0;
  logic [DW-1:0]  m_od = '0;
  logic [DW-1:0]  exp_q [$];
  vec_t           vecs [NV];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  function automatic logic [15:0][DW-1:0] mk_ramp(input int start, input int dir);
    logic [15:0][DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k] = DW'(start + k * dir);
    return r;
  endfunction

  // One cycle: check outputs against the expected state, drive inputs,
  // then advance the expected state across the coming rising edge.
  task automatic step(input logic pl, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    chk("in_ready", {15'd0, bus.in_ready}, {15'd0, m_state == 1});
    chk("done_p", {15'd0, done_p}, {15'd0, m_state == 2});
    chk("out_valid", {15'd0, bus.out_valid}, {15'd0, m_ov});
    chk("out_data", bus.out_data, m_od);
    if (done_p === 1'b1) done_seen++;
    p_load       = pl;
    bus.in_valid = v;
    bus.in_data  = d;
    m_ov = 1'b0;
    case (m_state)
      0: if (pl) begin m_state = 1; m_idx = 0; end
      1: if (v) begin
        if ((m_idx % 2 == 1) && ((m_idx / W) % 2 == 1)) begin
          m_ov = 1'b1;
          if (exp_q.size() > 0) m_od = exp_q.pop_front();
          else begin
            checks++; errors++;
            $display("FAIL exp_underflow: got output slot, want none at %0t", $time);
          end
        end
        if (m_idx == W * H - 1) m_state = 2;
        m_idx++;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic run_frame(input vec_t v);
    int   i;
    int   cyc;
    logic vld;
    logic pl;
    if (v.gap) begin
      for (int k = 0; k < 2; k++) step(1'b0, v.idle_valid, 16'h7fff);
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(v.exp[k]);
    step(1'b1, 1'b0, '0);
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 100) begin
      vld = v.bubble ? (cyc % 2 == 0) : 1'b1;
      pl  = v.extra_pl && (cyc % 3 == 1);
      step(pl, vld, vld ? v.pix[i] : 16'hdead);
      if (vld) i++;
      cyc++;
    end
    // DONE cycle is checked here; a start pulse now must be ignored
    step(v.extra_pl, v.idle_valid, 16'h7fff);
    chk("outs_remaining", DW'(exp_q.size()), '0);
  endtask

  initial begin
    int neg1 [16];
    int mix [16];
    mix = '{-5, 3, -100, -200, -7, -8, -300, -150, 32767, -32768, 0, 0, -1, -2, 0, -1};
    for (int k = 0; k < 16; k++) neg1[k] = -1;
    neg1[5]  = -32768;
    neg1[15] = -2;

    for (int n = 0; n < NV; n++) begin
      vecs[n] = '0;
      vecs[n].pix = mk_ramp(0, 1);
      vecs[n].exp = {16'd15, 16'd13, 16'd7, 16'd5};
    end
    vecs[0].gap = 1'b1;
    for (int k = 0; k < 16; k++) vecs[1].pix[k] = DW'(neg1[k]);
    vecs[1].exp = {16'hffff, 16'hffff, 16'hffff, 16'hffff};
    for (int k = 0; k < 16; k++) vecs[2].pix[k] = DW'(mix[k]);
    vecs[2].exp = {16'd0, 16'd32767, 16'hff9c, 16'd3};
    vecs[3].bubble = 1'b1;
    vecs[4].extra_pl = 1'b1;
    vecs[4].idle_valid = 1'b1;
    vecs[4].gap = 1'b1;
    vecs[5].gap = 1'b1;
    vecs[6].pix = mk_ramp(15, -1);
    vecs[6].exp = {16'd5, 16'd7, 16'd13, 16'd15};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {15'd0, bus.in_ready}, '0);
    chk("rst_out_valid", {15'd0, bus.out_valid}, '0);
    chk("rst_done_p", {15'd0, done_p}, '0);
    chk("rst_out_data", bus.out_data, '0);
    reset_n = 1'b1;

    for (int n = 0; n < NV; n++) run_frame(vecs[n]);

    // Mid-frame reset after pixel 9 abandons the frame
    step(1'b0, 1'b0, '0);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd7);
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, DW'(k));
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    p_load       = 1'b0;
    #1;
    chk("mid_rst_in_ready", {15'd0, bus.in_ready}, '0);
    chk("mid_rst_out_valid", {15'd0, bus.out_valid}, '0);
    chk("mid_rst_done_p", {15'd0, done_p}, '0);
    chk("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_outs_left", DW'(exp_q.size()), '0);
    m_state = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    @(negedge clk);
    reset_n = 1'b1;
    begin
      vec_t rv;
      rv = '0;
      rv.pix = mk_ramp(16, 1);
      rv.exp = {16'd31, 16'd29, 16'd23, 16'd21};
      rv.gap = 1'b1;
      run_frame(rv);
    end

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'h1234);
    chk("done_count", DW'(done_seen), DW'(NV + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameter DATA_W, default 16: width of the signed two's-complement feature-map sample.
REQ-002 Parameter IMG_W, default 24: input map width in pixels; even, >= 2.
REQ-003 Parameter IMG_H, default 24: input map height in pixels; even, >= 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 p_load  input  1  one-cycle start pulse from CONTROLLER (its p_load_1/p_load_2).
REQ-007 in_valid  input  1  in_data holds a valid ReLU-stage sample this cycle.
REQ-008 in_data  input  DATA_W  signed input sample, raster order (row-major, column 0 first).
REQ-009 in_ready  output  1  block accepts samples; a sample transfers when in_valid && in_ready.
REQ-010 out_valid  output  1  out_data holds a valid pooled sample this cycle.
REQ-011 out_data  output  DATA_W  signed pooled sample, raster order of the (IMG_W/2)x(IMG_H/2) output map.
REQ-012 done_p  output  1  one-cycle pulse to CONTROLLER (its done_p_1/done_p_2) at frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=0; p_load=1 SHALL clear row/column counters and move to RUN next cycle.
REQ-015 RUN: in_ready=1; each transfer SHALL advance the column counter, wrapping IMG_W-1 -> 0 and incrementing the row counter.
REQ-016 Even column transfer SHALL register the sample in a hold register.
REQ-017 Odd column transfer SHALL form pair_max = signed max(hold, in_data).
REQ-018 Even row, odd column: pair_max SHALL be written to line-buffer entry col>>1 (IMG_W/2 entries of DATA_W bits); no output.
REQ-019 Odd row, odd column: out_data SHALL be signed max(line_buf[col>>1], pair_max), registered, with out_valid=1 exactly one cycle after the transfer.
REQ-020 out_valid SHALL be 0 in every cycle not defined by REQ-019; out_data holds its last value otherwise.
REQ-021 Comparisons SHALL be signed; equal operands yield that value; no saturation or width change.
REQ-022 Transfer of pixel (IMG_H-1, IMG_W-1) SHALL move the FSM to DONE; in that cycle the last pooled sample is registered.
REQ-023 DONE SHALL last exactly one cycle with done_p=1 and in_ready=0, coinciding with the final out_valid, then return to IDLE.
REQ-024 in_valid=0 cycles in RUN SHALL stall the counters with no state loss; bubbles of any length allowed.
REQ-025 p_load in RUN or DONE SHALL be ignored; in_valid in IDLE or DONE SHALL be ignored.
REQ-026 Exactly (IMG_W/2)*(IMG_H/2) out_valid pulses and one done_p pulse SHALL occur per frame.
REQ-027 Back-to-back frames: p_load in the cycle after done_p SHALL start a new frame correctly.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, counters 0, in_ready=0, out_valid=0, done_p=0, out_data=0, hold=0.
REQ-029 Line-buffer contents need not be reset; they SHALL never be read before being written in the current frame.
REQ-030 Reset mid-frame SHALL abandon the frame; no out_valid or done_p until a new p_load-started frame.

Verification (IMG_W=4, IMG_H=4, DATA_W=16)
REQ-031 p_load, then 0..15 raster with in_valid constant 1 -> out_data 5,7,13,15 in order, done_p with the 15 output, then IDLE.
REQ-032 Frame of all -1 except pixel (1,1)=-32768 and pixel (3,3)=-2 -> outputs -1,-1,-1,-1 (signed compare check).
REQ-033 Input of REQ-031 with in_valid toggling 1,0,1,0 -> same 4 outputs, each one cycle after its odd/odd transfer.
REQ-034 Extra p_load pulses during RUN plus in_valid high while IDLE -> no effect; results identical to REQ-031.
REQ-035 reset_n low for one cycle after pixel 9, then p_load and 16..31 raster -> outputs 21,23,29,31 only, one done_p.
REQ-036 Two frames, second p_load the cycle after first done_p, data 0..15 then 15..0 -> 5,7,13,15 then 15,13,7,5 (second frame: 15..0 gives 15,13,7,5).
